// File: rtl/spi_bus_arb.sv
// Round-robin arbiter that shares one 16-bit SPI master between the A2D sequencer (0)
// and the inertial sensor interface (1), with an optional lock for back-to-back transactions.
module spi_bus_arb #(
  parameter int unsigned LOCK_TO = 32,
  parameter int unsigned LTW     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt0,
  input  logic [15:0] cmd0,
  input  logic        lock0,
  output logic        done0,
  input  logic        wrt1,
  input  logic [15:0] cmd1,
  input  logic        lock1,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic [1:0]  err,
  output logic        m_wrt,
  output logic [15:0] m_cmd,
  input  logic        m_done,
  input  logic [15:0] m_rd_data,
  input  logic        m_ss_n,
  output logic        ss_n0,
  output logic        ss_n1,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_t;

  state_t          state;
  logic [1:0]      pend;
  logic [1:0]      hlock;
  logic [15:0]     hcmd0;
  logic [15:0]     hcmd1;
  logic            last;
  logic            lock_q;
  logic [LTW-1:0]  lock_cnt;

  logic [1:0]      wrt_v_c;
  logic            grant_c;
  logic            grant_id_c;
  logic [1:0]      grant_mask_c;

  assign wrt_v_c = {wrt1, wrt0};

  // Grant decision: IDLE serves any pending requester (ties go to the one not served last);
  // HOLD only serves the locked owner.
  always_comb begin
    grant_c    = 1'b0;
    grant_id_c = 1'b0;
    case (state)
      IDLE: begin
        case (pend)
          2'b01:   begin grant_c = 1'b1; grant_id_c = 1'b0;  end
          2'b10:   begin grant_c = 1'b1; grant_id_c = 1'b1;  end
          2'b11:   begin grant_c = 1'b1; grant_id_c = ~last; end
          default: begin grant_c = 1'b0; grant_id_c = 1'b0;  end
        endcase
      end
      HOLD: begin
        grant_c    = pend[owner];
        grant_id_c = owner;
      end
      default: begin
        grant_c    = 1'b0;
        grant_id_c = 1'b0;
      end
    endcase
    grant_mask_c = grant_c ? (grant_id_c ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend     <= 2'b00;
      hlock    <= 2'b00;
      hcmd0    <= 16'h0000;
      hcmd1    <= 16'h0000;
      owner    <= 1'b0;
      last     <= 1'b1;
      lock_q   <= 1'b0;
      lock_cnt <= '0;
      m_cmd    <= 16'h0000;
      m_wrt    <= 1'b0;
      err      <= 2'b00;
    end else begin
      m_wrt <= 1'b0;
      // A write landing on an already-pending slot is dropped and flagged.
      err   <= wrt_v_c & pend;
      pend  <= (pend & ~grant_mask_c) | (wrt_v_c & ~pend);
      if (wrt0 && !pend[0]) begin
        hcmd0    <= cmd0;
        hlock[0] <= lock0;
      end
      if (wrt1 && !pend[1]) begin
        hcmd1    <= cmd1;
        hlock[1] <= lock1;
      end

      if (grant_c) begin
        owner  <= grant_id_c;
        m_cmd  <= grant_id_c ? hcmd1 : hcmd0;
        lock_q <= hlock[grant_id_c];
        m_wrt  <= 1'b1;
        state  <= ISSUE;
      end else begin
        case (state)
          ISSUE: state <= BUSY;
          BUSY: begin
            if (m_done) begin
              if (lock_q) begin
                lock_cnt <= '0;
                state    <= HOLD;
              end else begin
                last  <= owner;
                state <= IDLE;
              end
            end
          end
          HOLD: begin
            if (lock_cnt == LTW'(LOCK_TO - 32'd1)) begin
              last  <= owner;
              state <= IDLE;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Done pulse, read data and slave select are steered combinationally to the owner.
  assign done0   = (state == BUSY) && m_done && !owner;
  assign done1   = (state == BUSY) && m_done && owner;
  assign rd_data = m_rd_data;
  assign ss_n0   = owner ? 1'b1 : m_ss_n;
  assign ss_n1   = owner ? m_ss_n : 1'b1;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spi_bus_arb.sv
// Bench for spi_bus_arb: directed scenarios plus randomized request patterns checked
// against a transaction-level round-robin model.
module tb_spi_bus_arb;

  localparam int unsigned LOCK_TO = 32;
  localparam int unsigned LTW     = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt0, wrt1, lock0, lock1;
  logic [15:0] cmd0, cmd1;
  logic        done0, done1;
  logic [15:0] rd_data;
  logic [1:0]  err;
  logic        m_wrt;
  logic [15:0] m_cmd;
  logic        m_done;
  logic [15:0] m_rd_data;
  logic        m_ss_n;
  logic        ss_n0, ss_n1;
  logic        owner, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_bus_arb #(.LOCK_TO(LOCK_TO), .LTW(LTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wrt0(wrt0), .cmd0(cmd0), .lock0(lock0), .done0(done0),
    .wrt1(wrt1), .cmd1(cmd1), .lock1(lock1), .done1(done1),
    .rd_data(rd_data), .err(err),
    .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done), .m_rd_data(m_rd_data),
    .m_ss_n(m_ss_n), .ss_n0(ss_n0), .ss_n1(ss_n1),
    .owner(owner), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference rule: a lone request wins; on a tie the requester not served last wins.
  function automatic logic pick(input bit p0, input bit p1, input logic last_served);
    if (p0 && p1) return ~last_served;
    return p1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wrt(input logic id, input logic [15:0] c, input logic lk);
    if (id) begin
      wrt1 = 1'b1; cmd1 = c; lock1 = lk;
    end else begin
      wrt0 = 1'b1; cmd0 = c; lock0 = lk;
    end
  endtask

  task automatic clear_wrt();
    wrt0 = 1'b0;
    wrt1 = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_wrt();
    m_done = 1'b0;
    m_ss_n = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_mwrt(input int budget, output int n);
    n = 0;
    while (m_wrt !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  // Waits for the issue, plays the SPI master for one transaction, optionally has the
  // owner re-request in the m_done cycle. Returns in the cycle after m_done.
  task automatic do_txn(input logic exp_owner, input logic [15:0] exp_cmd, input int dly,
                        input bit rew, input logic [15:0] rew_cmd, input logic rew_lock,
                        input logic [15:0] rd);
    int n;
    wait_mwrt(80, n);
    checks++;
    if (m_wrt !== 1'b1) begin
      errors++;
      $display("FAIL txn_issue: m_wrt=%b after %0d cycles, required 1", m_wrt, n);
    end
    checks++;
    if (m_cmd !== exp_cmd || owner !== exp_owner) begin
      errors++;
      $display("FAIL txn_grant: owner=%b m_cmd=%h, required owner=%b m_cmd=%h",
               owner, m_cmd, exp_owner, exp_cmd);
    end
    step();
    checks++;
    if (m_wrt !== 1'b0) begin
      errors++;
      $display("FAIL txn_wrt_pulse: m_wrt=%b one cycle after issue, required 0", m_wrt);
    end
    m_ss_n = 1'b0;
    #1;
    checks++;
    if ({ss_n1, ss_n0} !== (exp_owner ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL txn_ss: ss_n1=%b ss_n0=%b with owner %b", ss_n1, ss_n0, exp_owner);
    end
    repeat (dly) step();
    m_rd_data = rd;
    m_done    = 1'b1;
    if (rew) drive_wrt(exp_owner, rew_cmd, rew_lock);
    #1;
    checks++;
    if ({done1, done0} !== (exp_owner ? 2'b10 : 2'b01) || rd_data !== rd) begin
      errors++;
      $display("FAIL txn_done: done1=%b done0=%b rd_data=%h, required owner %b data %h",
               done1, done0, rd_data, exp_owner, rd);
    end
    step();
    m_done = 1'b0;
    m_ss_n = 1'b1;
    clear_wrt();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wrt0 = 1'b0; wrt1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    cmd0 = 16'h0; cmd1 = 16'h0;
    m_done = 1'b0; m_rd_data = 16'h0; m_ss_n = 1'b1;
    repeat (2) step();
    checks++;
    if (busy !== 1'b0 || m_wrt !== 1'b0 || m_cmd !== 16'h0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b m_wrt=%b m_cmd=%h owner=%b, required 0 0 0000 0",
               busy, m_wrt, m_cmd, owner);
    end
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0 || err !== 2'b00 || ss_n0 !== 1'b1 || ss_n1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: done0=%b done1=%b err=%b ss_n0=%b ss_n1=%b",
               done0, done1, err, ss_n0, ss_n1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive_wrt(1'b0, 16'h2000, 1'b0);
    step();
    clear_wrt();
    checks++;
    if (m_wrt !== 1'b0) begin
      errors++;
      $display("FAIL single_early: m_wrt=%b one cycle after wrt0, required 0", m_wrt);
    end
    step();
    checks++;
    if (m_wrt !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: m_wrt=%b two cycles after wrt0, required 1", m_wrt);
    end
    do_txn(1'b0, 16'h2000, 2, 1'b0, 16'h0, 1'b0, 16'h0ABC);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b after done, required 0", busy);
    end
  endtask

  task automatic test_tie();
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      drive_wrt(1'b0, 16'h1000 + 16'(r), 1'b0);
      drive_wrt(1'b1, 16'h8000 + 16'(r), 1'b0);
      step();
      clear_wrt();
      do_txn(1'b0, 16'h1000 + 16'(r), 1, 1'b0, 16'h0, 1'b0, 16'(r));
      do_txn(1'b1, 16'h8000 + 16'(r), 0, 1'b0, 16'h0, 1'b0, 16'(r + 7));
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_idle: busy=%b after tie rounds, required 0", busy);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    drive_wrt(1'b0, 16'h3100, 1'b1);
    drive_wrt(1'b1, 16'hB200, 1'b0);
    step();
    clear_wrt();
    do_txn(1'b0, 16'h3100, 1, 1'b0, 16'h0, 1'b0, 16'h1111);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold: busy=%b after locked done, required 1", busy);
    end
    drive_wrt(1'b0, 16'h3300, 1'b0);
    step();
    clear_wrt();
    checks++;
    if (m_wrt !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: m_wrt=%b one cycle after re-request, required 0", m_wrt);
    end
    step();
    checks++;
    if (m_wrt !== 1'b1 || owner !== 1'b0 || m_cmd !== 16'h3300) begin
      errors++;
      $display("FAIL lock_reissue: m_wrt=%b owner=%b m_cmd=%h, required 1 0 3300",
               m_wrt, owner, m_cmd);
    end
    do_txn(1'b0, 16'h3300, 0, 1'b0, 16'h0, 1'b0, 16'h2222);
    do_txn(1'b1, 16'hB200, 0, 1'b0, 16'h0, 1'b0, 16'h3333);
  endtask

  task automatic test_lock_timeout();
    int n;
    apply_reset();
    drive_wrt(1'b0, 16'h4400, 1'b1);
    drive_wrt(1'b1, 16'hC500, 1'b0);
    step();
    clear_wrt();
    do_txn(1'b0, 16'h4400, 0, 1'b0, 16'h0, 1'b0, 16'h4444);
    wait_mwrt(100, n);
    // LOCK_TO cycles in HOLD plus one IDLE cycle before the waiting request issues.
    checks++;
    if (m_wrt !== 1'b1 || n != int'(LOCK_TO) + 1 || owner !== 1'b1 || m_cmd !== 16'hC500) begin
      errors++;
      $display("FAIL lock_timeout: m_wrt=%b after %0d cycles owner=%b m_cmd=%h, required %0d cycles owner 1 C500",
               m_wrt, n, owner, m_cmd, LOCK_TO + 1);
    end
    do_txn(1'b1, 16'hC500, 1, 1'b0, 16'h0, 1'b0, 16'h5555);
  endtask

  task automatic test_overflow();
    int n;
    apply_reset();
    drive_wrt(1'b0, 16'h0A00, 1'b0);
    step();
    clear_wrt();
    wait_mwrt(10, n);
    step();
    drive_wrt(1'b1, 16'hD100, 1'b0);
    step();
    drive_wrt(1'b1, 16'hD200, 1'b0);
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("FAIL ovf_first: err=%b after first wrt1, required 00", err);
    end
    step();
    clear_wrt();
    checks++;
    if (err !== 2'b10) begin
      errors++;
      $display("FAIL ovf_err: err=%b after dropped wrt1, required 10", err);
    end
    step();
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("FAIL ovf_pulse: err=%b, required 00", err);
    end
    m_rd_data = 16'h6666;
    m_done    = 1'b1;
    #1;
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_done0: done0=%b done1=%b, required 1 0", done0, done1);
    end
    step();
    m_done = 1'b0;
    do_txn(1'b1, 16'hD100, 1, 1'b0, 16'h0, 1'b0, 16'h7777);
    m_done = 1'b1;
    #1;
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: done0=%b done1=%b in IDLE, required 0 0", done0, done1);
    end
    step();
    m_done = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || m_wrt !== 1'b0) begin
      errors++;
      $display("FAIL stray_state: busy=%b m_wrt=%b after stray done, required 0 0", busy, m_wrt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    apply_reset();
    drive_wrt(1'b0, 16'h0B00, 1'b0);
    step();
    clear_wrt();
    wait_mwrt(10, n);
    step();
    drive_wrt(1'b1, 16'hE100, 1'b0);
    step();
    clear_wrt();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || m_wrt !== 1'b0) begin
      errors++;
      $display("FAIL midreset: busy=%b m_wrt=%b during reset, required 0 0", busy, m_wrt);
    end
    step();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      step();
      if (busy !== 1'b0 || m_wrt !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midreset_pend: arbiter became busy after reset release, required idle");
    end
    drive_wrt(1'b1, 16'hE200, 1'b0);
    step();
    clear_wrt();
    step();
    checks++;
    if (m_wrt !== 1'b1 || owner !== 1'b1 || m_cmd !== 16'hE200) begin
      errors++;
      $display("FAIL midreset_fresh: m_wrt=%b owner=%b m_cmd=%h, required 1 1 E200",
               m_wrt, owner, m_cmd);
    end
    do_txn(1'b1, 16'hE200, 1, 1'b0, 16'h0, 1'b0, 16'h8888);
  endtask

  task automatic test_random();
    bit [1:0]    p;
    logic [15:0] hc [2];
    logic        last_served;
    logic        w;
    logic [1:0]  mask;
    bit          rew;
    logic [15:0] nc;
    int          rewrites;
    apply_reset();
    last_served = 1'b1;
    p = 2'b00;
    for (int it = 0; it < 30; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        if (mask[i]) begin
          p[i]  = 1'b1;
          hc[i] = 16'($urandom);
          drive_wrt(1'(i), hc[i], 1'b0);
        end
      end
      step();
      clear_wrt();
      rewrites = 0;
      while (p != 2'b00) begin
        w    = pick(p[0], p[1], last_served);
        p[w] = 1'b0;
        rew  = (rewrites < 4) && ($urandom_range(0, 2) == 0);
        nc   = 16'($urandom);
        do_txn(w, hc[w], $urandom_range(0, 4), rew, nc, 1'b0, 16'($urandom));
        last_served = w;
        if (rew) begin
          p[w]  = 1'b1;
          hc[w] = nc;
          rewrites++;
        end
      end
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL random_idle: busy=%b after random traffic, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_lock_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arb.md
Name: spi_bus_arb

Overview:
- Shares one 16-bit SPI master between two requesters: requester 0 is the A2D channel sequencer, requester 1 is the inertial sensor interface.
- Captures each requester's one-cycle write strobe and command, and grants the master round-robin.
- Routes the master's done pulse back to the owning requester and steers the master's slave-select to the owner's device.
- Supports a lock so a requester can issue back-to-back transactions without interleaving (the A2D needs a channel-select transaction followed by a read).

Parameters:
- LOCK_TO, 32: cycles the arbiter holds a locked grant in HOLD waiting for the owner's next write before releasing.
- LTW, 6: width of the lock timeout counter; must satisfy 2^LTW > LOCK_TO.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- wrt0  in  1  requester 0 write strobe, one-cycle pulse
- cmd0  in  16  requester 0 command, valid with wrt0
- lock0  in  1  sampled with wrt0; 1 = keep grant after this transaction
- done0  out  1  requester 0 transaction complete, one-cycle pulse
- wrt1, cmd1, lock1, done1  same as above, for requester 1
- rd_data  out  16  read data to both requesters, valid with done0/done1
- err  out  2  one-cycle pulse per requester: write dropped (overflow)
- m_wrt  out  1  master write strobe
- m_cmd  out  16  master command
- m_done  in  1  master done pulse
- m_rd_data  in  16  master read data
- m_ss_n  in  1  master slave select
- ss_n0  out  1  device 0 slave select
- ss_n1  out  1  device 1 slave select
- owner  out  1  current/last granted requester
- busy  out  1  high in ISSUE, BUSY or HOLD

Behaviour:
- Reset: state=IDLE, pend0=pend1=0, owner=0, last=1, lock_q=0, lock counter=0, m_cmd=0. All pulse outputs are 0. ss_n0/ss_n1 follow the gating rule below, so both are 1 while m_ss_n=1.
- Capture: wrtX at an edge sets pendX and stores cmdX/lockX in a per-requester holding register.
  - If pendX is already set at that edge, the new write is dropped, the held data is kept, and err[X] pulses the next cycle.
  - Capture is legal in any state, including while X owns the bus.
- IDLE:
  - If exactly one pend is set, grant it.
  - If both are set, grant the requester != last.
  - On grant: owner<=X, m_cmd<=held cmd, lock_q<=held lock, pendX<=0, go to ISSUE.
- ISSUE: m_wrt=1 for exactly one cycle; go to BUSY.
- BUSY:
  - Wait for m_done.
  - On the m_done cycle, done[owner]=m_done combinationally; rd_data=m_rd_data passthrough at all times.
  - If lock_q=1, go to HOLD and clear the lock counter; else last<=owner and go to IDLE.
- HOLD:
  - If pend[owner] is set, grant owner exactly as in IDLE (refresh lock_q) and go to ISSUE. The other requester's pend waits.
  - Otherwise increment the counter. When the counter == LOCK_TO-1, last<=owner and go to IDLE.
- Latency: wrtX high in cycle t -> m_wrt high in cycle t+2 when the arbiter is IDLE. In HOLD, a locked owner's re-request also reaches ISSUE at t+2.
- Slave select: ss_n0 = (owner==0) ? m_ss_n : 1; ss_n1 = (owner==1) ? m_ss_n : 1. Never both low.
- m_cmd is stable from ISSUE until the next grant.
- m_done outside BUSY is ignored: no done pulse, no state change.
- Simultaneous events:
  - wrtX coinciding with m_done for owner X sets pendX (this is the A2D back-to-back case).
  - wrt0 and wrt1 in the same cycle both capture.
- Reset mid-transaction: aborts immediately to the reset values; pending requests are lost.

Test Plan:
- Single request: wrt0 with cmd0=16'h2000, lock0=0 -> m_wrt high 2 cycles later, m_cmd=16'h2000, ss_n0 tracks m_ss_n, ss_n1=1. On m_done with m_rd_data=16'h0ABC: done0=1, rd_data=16'h0ABC, done1=0. State returns to IDLE.
- Tie and round-robin: wrt0 and wrt1 in the same cycle from reset -> requester 0 granted first, then requester 1. Repeat the tie -> order is 0 then 1 again (last toggles correctly). With requester 1 re-requesting continuously, requester 0 is never starved for more than one transaction.
- Lock: wrt0 with lock0=1 while pend1 is set. Requester 0 re-requests the cycle after done0 -> its second transaction is issued before requester 1, and m_wrt high is exactly 2 cycles after the re-request.
- Lock timeout: lock0=1, no re-request, pend1 set -> after LOCK_TO=32 cycles in HOLD, requester 1 is granted.
- Overflow: wrt1 twice while BUSY for owner 0 -> err[1] pulses once and the first cmd1 is the one issued. A stray m_done in IDLE produces no done pulse.
- Reset mid-BUSY: assert rst_n low -> busy=0, m_wrt=0, pends cleared. After release, a fresh wrt1 is served normally.
